// File: rtl/gf180mcu_osu_sc_gp12t3v3__inv_bist.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : gf180mcu_osu_sc_gp12t3v3__inv_bist
//  Purpose  : Built-in self-test checker for a bank of WIDTH inverter cells.
//             Drives a fixed plus LFSR pattern set onto the cells. It waits
//             SETTLE cycles per pattern and then checks that each read-back
//             bit is the complement of its drive bit. It reports pass/fail,
//             a saturating error count and the index of the first failing
//             pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_osu_sc_gp12t3v3__inv_bist #(
  parameter int          WIDTH  = 8,
  parameter int          NPAT   = 16,
  parameter int          SETTLE = 2,
  parameter int          CNT_W  = 8,
  parameter logic [15:0] SEED   = 16'hACE1,
  localparam int         IDX_W  = (NPAT > 1) ? $clog2(NPAT) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic [WIDTH-1:0] DUT_A,
  input  logic [WIDTH-1:0] DUT_Y,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [IDX_W-1:0] FIRST_FAIL_IDX
);

  // The wait counter holds values 1..SETTLE; it is unused when SETTLE is 0.
  localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  localparam logic [15:0] C_ONES = 16'hFFFF;
  localparam logic [15:0] C_PAT2 = 16'h5555;
  localparam logic [15:0] C_PAT3 = 16'hAAAA;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   dut_a_q,  dut_a_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               pass_q,   pass_d;
  logic [CNT_W-1:0]   err_q,    err_d;
  logic [IDX_W-1:0]   first_q,  first_d;
  logic               fail_q,   fail_d;
  logic [15:0]        lfsr_q,   lfsr_d;
  logic [IDX_W-1:0]   idx_q,    idx_d;
  logic [WAIT_W-1:0]  wcnt_q,   wcnt_d;

  logic [15:0]        w_lfsr_nxt;
  logic [31:0]        w_idx_nxt;
  logic               w_last;
  logic               w_fail;
  logic [WIDTH-1:0]   w_pat_nxt;

  // Fibonacci right shift; the feedback bit enters at bit 15.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  assign w_lfsr_nxt = lfsr_step(lfsr_q);
  assign w_idx_nxt  = 32'(idx_q) + 32'd1;
  assign w_last     = (32'(idx_q) == 32'(NPAT - 1));
  // A pattern fails if any read-back bit equals its drive bit.
  assign w_fail     = |(~(DUT_Y ^ dut_a_q));

  // Select the pattern for the next index: four fixed words, then the
  // seed itself, then one LFSR step per further pattern.
  always_comb begin
    w_pat_nxt = w_lfsr_nxt[WIDTH-1:0];
    if (w_idx_nxt == 32'd1) begin
      w_pat_nxt = C_ONES[WIDTH-1:0];
    end else if (w_idx_nxt == 32'd2) begin
      w_pat_nxt = C_PAT2[WIDTH-1:0];
    end else if (w_idx_nxt == 32'd3) begin
      w_pat_nxt = C_PAT3[WIDTH-1:0];
    end else if (w_idx_nxt == 32'd4) begin
      w_pat_nxt = lfsr_q[WIDTH-1:0];
    end
  end

  // Next-state and datapath: start a run, count settle cycles, score patterns.
  always_comb begin
    state_d = state_q;
    dut_a_d = dut_a_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;
    fail_d  = fail_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          dut_a_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          first_d = '0;
          fail_d  = 1'b0;
          lfsr_d  = SEED;
          idx_d   = '0;
          if (SETTLE > 0) begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_W'(SETTLE);
          end else begin
            state_d = S_SAMPLE;
          end
        end
      end

      S_WAIT: begin
        if (wcnt_q == WAIT_W'(1)) begin
          state_d = S_SAMPLE;
        end else begin
          wcnt_d = wcnt_q - WAIT_W'(1);
        end
      end

      S_SAMPLE: begin
        if (w_fail) begin
          fail_d = 1'b1;
          if (err_q != {CNT_W{1'b1}}) begin
            err_d = err_q + CNT_W'(1);
          end
          if (!fail_q) begin
            first_d = idx_q;
          end
        end
        if (w_last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = !(fail_q || w_fail);
          dut_a_d = '0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          dut_a_d = w_pat_nxt;
          // The register advances only for patterns beyond the seed.
          if (w_idx_nxt >= 32'd5) begin
            lfsr_d = w_lfsr_nxt;
          end
          if (SETTLE > 0) begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_W'(SETTLE);
          end else begin
            state_d = S_SAMPLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset that overrides any run in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      dut_a_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      fail_q  <= 1'b0;
      lfsr_q  <= SEED;
      idx_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dut_a_q <= dut_a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
      fail_q  <= fail_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign DUT_A          = dut_a_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign PASS           = pass_q;
  assign ERR_CNT        = err_q;
  assign FIRST_FAIL_IDX = first_q;

endmodule
`default_nettype wire
